// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts a byte over valid/ready and shifts out one
// start bit, DATA_BITS LSB-first data bits and STOP_BITS stop bits on tx_out_o.
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] brd_i,
  input  logic        tx_valid_i,
  input  logic [7:0]  tx_data_i,
  output logic        tx_ready_o,
  output logic        tx_busy_o,
  output logic        tx_done_o,
  output logic        tx_out_o
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_q, stop_d;
  logic        tx_out_q, tx_out_d;
  logic        done_q, done_d;
  logic        bit_tick;
  logic        accept;

  // div_q holds the effective divisor (never zero while a frame is active)
  assign bit_tick = (baud_q == (div_q - 16'd1));
  assign accept   = tx_valid_i && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    baud_d    = (bit_tick) ? 16'd0 : baud_q + 16'd1;
    div_d     = div_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    stop_d    = stop_q;
    tx_out_d  = tx_out_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d   = 16'd0;
        tx_out_d = 1'b1;
        if (accept) begin
          state_d   = START;
          div_d     = (brd_i == 16'd0) ? 16'd1 : brd_i;
          shift_d   = tx_data_i;
          bit_idx_d = 3'd0;
          stop_d    = 1'b0;
          tx_out_d  = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_out_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d  = STOP;
            stop_d   = 1'b0;
            tx_out_d = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            tx_out_d  = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      baud_q    <= 16'd0;
      div_q     <= 16'd0;
      shift_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      stop_q    <= 1'b0;
      tx_out_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      div_q     <= div_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      stop_q    <= stop_d;
      tx_out_q  <= tx_out_d;
      done_q    <= done_d;
    end
  end

  assign tx_busy_o  = (state_q != IDLE);
  assign tx_ready_o = (state_q == IDLE);
  assign tx_done_o  = done_q;
  assign tx_out_o   = tx_out_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frame shape, back-to-back, divisor
// edge cases, ignored mid-frame requests, brd changes and mid-frame reset.
module tb_uart_tx_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] brd = 16'd4;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready, tx_busy, tx_done, tx_out;

  int checks = 0;
  int errors = 0;

  logic cap_out   [0:511];
  logic cap_done  [0:511];
  logic cap_ready [0:511];

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .brd_i      (brd),
    .tx_valid_i (tx_valid),
    .tx_data_i  (tx_data),
    .tx_ready_o (tx_ready),
    .tx_busy_o  (tx_busy),
    .tx_done_o  (tx_done),
    .tx_out_o   (tx_out)
  );

  always #5 clk = ~clk;

  // Expected line level i cycles after the accepting edge of an 8N1 frame.
  function automatic logic exp_bit(input logic [7:0] d, input int eff, input int i);
    int b;
    b = i / eff;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic send(input logic [15:0] b, input logic [7:0] d);
    @(negedge clk);
    brd      = b;
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  // Samples n cycles; optionally pulses tx_valid or changes brd at given samples.
  task automatic capture(input int n, input int pulse_at, input logic [7:0] pulse_data,
                         input int brd_at, input logic [15:0] brd_new);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_out[i]   = tx_out;
      cap_done[i]  = tx_done;
      cap_ready[i] = tx_ready;
      if (i == pulse_at) begin
        tx_valid = 1'b1;
        tx_data  = pulse_data;
      end else if (pulse_at >= 0 && i == pulse_at + 1) begin
        tx_valid = 1'b0;
      end
      if (i == brd_at) brd = brd_new;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out=%b ready=%b busy=%b done=%b required 1 1 0 0",
               tx_out, tx_ready, tx_busy, tx_done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: out=%b ready=%b required 1 1", tx_out, tx_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_a5;
    send(16'd4, 8'hA5);
    capture(41, -1, 8'h00, -1, 16'd0);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (cap_out[i] !== exp_bit(8'hA5, 4, i) || cap_done[i] !== 1'b0 || cap_ready[i] !== 1'b0) begin
        errors++;
        $display("FAIL t1_frame[%0d]: out=%b done=%b ready=%b required out=%b done=0 ready=0",
                 i, cap_out[i], cap_done[i], cap_ready[i], exp_bit(8'hA5, 4, i));
      end
    end
    checks++;
    if (cap_done[40] !== 1'b1 || cap_ready[40] !== 1'b1 || cap_out[40] !== 1'b1) begin
      errors++;
      $display("FAIL t1_done: done=%b ready=%b out=%b required 1 1 1",
               cap_done[40], cap_ready[40], cap_out[40]);
    end
    $display("test_basic_a5 done");
  endtask

  task automatic test_back_to_back;
    int ndone;
    @(negedge clk);
    brd      = 16'd2;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(posedge clk);
    #1 tx_data = 8'hFF;
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      cap_out[i]  = tx_out;
      cap_done[i] = tx_done;
      if (i == 21) tx_valid = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (cap_out[i] !== exp_bit(8'h00, 2, i)) begin
        errors++;
        $display("FAIL t2_frame0[%0d]: out=%b required %b", i, cap_out[i], exp_bit(8'h00, 2, i));
      end
      checks++;
      if (cap_out[i+21] !== exp_bit(8'hFF, 2, i)) begin
        errors++;
        $display("FAIL t2_frame1[%0d]: out=%b required %b", i, cap_out[i+21], exp_bit(8'hFF, 2, i));
      end
    end
    checks++;
    if (cap_done[20] !== 1'b1 || cap_done[41] !== 1'b1) begin
      errors++;
      $display("FAIL t2_done_pos: done@20=%b done@41=%b required 1 1", cap_done[20], cap_done[41]);
    end
    ndone = 0;
    for (int i = 0; i < 42; i++) if (cap_done[i] === 1'b1) ndone++;
    checks++;
    if (ndone != 2) begin
      errors++;
      $display("FAIL t2_done_count: got %0d required 2", ndone);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_brd_zero;
    send(16'd0, 8'h3C);
    capture(11, -1, 8'h00, -1, 16'd0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cap_out[i] !== exp_bit(8'h3C, 1, i)) begin
        errors++;
        $display("FAIL t3_frame[%0d]: out=%b required %b", i, cap_out[i], exp_bit(8'h3C, 1, i));
      end
    end
    checks++;
    if (cap_done[10] !== 1'b1 || cap_done[9] !== 1'b0) begin
      errors++;
      $display("FAIL t3_done: done@9=%b done@10=%b required 0 1", cap_done[9], cap_done[10]);
    end
    $display("test_brd_zero done");
  endtask

  task automatic test_ignore_busy;
    send(16'd8, 8'h55);
    capture(86, 20, 8'hAA, -1, 16'd0);
    for (int i = 0; i < 80; i++) begin
      checks++;
      if (cap_out[i] !== exp_bit(8'h55, 8, i) || cap_ready[i] !== 1'b0) begin
        errors++;
        $display("FAIL t4_frame[%0d]: out=%b ready=%b required out=%b ready=0",
                 i, cap_out[i], cap_ready[i], exp_bit(8'h55, 8, i));
      end
    end
    for (int i = 80; i < 86; i++) begin
      checks++;
      if (cap_out[i] !== 1'b1 || cap_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL t4_idle[%0d]: out=%b ready=%b required 1 1", i, cap_out[i], cap_ready[i]);
      end
    end
    $display("test_ignore_busy done");
  endtask

  task automatic test_brd_change;
    send(16'd4, 8'hF0);
    capture(41, -1, 8'h00, 10, 16'd16);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (cap_out[i] !== exp_bit(8'hF0, 4, i)) begin
        errors++;
        $display("FAIL t5_frame[%0d]: out=%b required %b", i, cap_out[i], exp_bit(8'hF0, 4, i));
      end
    end
    checks++;
    if (cap_done[40] !== 1'b1) begin
      errors++;
      $display("FAIL t5_done: done@40=%b required 1", cap_done[40]);
    end
    $display("test_brd_change done");
  endtask

  task automatic test_reset_mid_frame;
    int ndone;
    send(16'd4, 8'h81);
    capture(14, -1, 8'h00, -1, 16'd0);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (cap_out[i] !== exp_bit(8'h81, 4, i)) begin
        errors++;
        $display("FAIL t6_pre[%0d]: out=%b required %b", i, cap_out[i], exp_bit(8'h81, 4, i));
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL t6_async_reset: out=%b ready=%b busy=%b required 1 1 0", tx_out, tx_ready, tx_busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    capture(40, -1, 8'h00, -1, 16'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) if (cap_done[i] === 1'b1 || cap_out[i] !== 1'b1) ndone++;
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL t6_no_done: %0d cycles with done or low line, required 0", ndone);
    end
    send(16'd4, 8'h81);
    capture(41, -1, 8'h00, -1, 16'd0);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (cap_out[i] !== exp_bit(8'h81, 4, i)) begin
        errors++;
        $display("FAIL t6_frame[%0d]: out=%b required %b", i, cap_out[i], exp_bit(8'h81, 4, i));
      end
    end
    checks++;
    if (cap_done[40] !== 1'b1) begin
      errors++;
      $display("FAIL t6_done: done@40=%b required 1", cap_done[40]);
    end
    $display("test_reset_mid_frame done");
  endtask

  initial begin
    test_reset();
    test_basic_a5();
    test_back_to_back();
    test_brd_zero();
    test_ignore_busy();
    test_brd_change();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
